segment_memory_mc: RTL
======================

# segment_memory_mc

Multi-channel, depth-parametrised segment memory for the SpMV merge datapath. It generalises the two fixed buffer/stage-output memories of a segment into NUM_CH independent read/write channels. Same-cycle read/write collisions are resolved internally, with no match flags supplied by the caller. It adds a hardware clear sequencer and per-channel read-valid tracking through an early and a pipelined output stage. It sits between the segment controller and the merge stage, one instance per segment.

## Interface
- NUM_CH, 2, number of independent channels (≥1)
- DEPTH, 64, words per channel (≥2)
- ADDR_W, $clog2(DEPTH), address bits per channel
- DATA_W, 64, data bits per word
- M20K_MIN, 256, DEPTH at or above which M20K storage is used
- MLAB_MIN, 32, DEPTH at or above which MLAB storage is used; below this, flop storage
- clk  in  1  single clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- clr_req  in  1  pulse: start clearing all channels to zero
- busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- rd_en  in  NUM_CH  per-channel read request
- rd_addr  in  NUM_CH*ADDR_W  per-channel read address; channel c occupies bits [c*ADDR_W +: ADDR_W]
- wr_en  in  NUM_CH  per-channel write request
- wr_addr  in  NUM_CH*ADDR_W  per-channel write address
- wr_data  in  NUM_CH*DATA_W  per-channel write data
- out_en  in  NUM_CH  per-channel output-stage load enable (low = hold)
- rd_data_early  out  NUM_CH*DATA_W  read data, 1 cycle after request
- rd_valid_early  out  NUM_CH  qualifies rd_data_early
- rd_data  out  NUM_CH*DATA_W  registered read data
- rd_valid  out  NUM_CH  qualifies rd_data

## Operation
- Channels are fully independent; there is no cross-channel addressing.
- **Write:** when wr_en[c]=1 and busy=0, wr_data[c] is stored at wr_addr[c] on the rising edge.
- **Read:** when rd_en[c]=1 and busy=0, rd_data_early[c] holds mem[rd_addr[c]] in the next cycle, and rd_valid_early[c]=1.
- **Collision:** same cycle, same channel, rd_en & wr_en, rd_addr==wr_addr → write-first. The read returns wr_data, captured in an internal bypass register. The storage read is suppressed that cycle.
- **Write-then-read:** a write at cycle t followed by a read of the same address at t+1 returns the new data; no bypass is needed.
- **Output stage:** when out_en[c]=1, rd_data[c] and rd_valid[c] load rd_data_early[c] and rd_valid_early[c]. When out_en[c]=0, both hold.
- **Clear FSM states:**
  - IDLE: clr_req=1 → CLEAR, with counter=0 and busy=1.
  - CLEAR: writes zero to address counter in every channel, then counter+1. When counter==DEPTH-1, the FSM moves to IDLE and pulses clr_done for 1 cycle.
- While busy=1:
  - user rd_en and wr_en are ignored;
  - rd_valid_early is 0;
  - clr_req is ignored.
- clr_req arriving in the same cycle as the final clear write is ignored.
- Storage contents are not reset by rst_b. They are undefined until written or cleared.

## Timing
- **Reset values:** all outputs 0, FSM=IDLE, counter=0, bypass registers 0.
- **Read latency:** rd_data_early 1 cycle; rd_data 2 cycles when out_en=1 at cycle t+1.
- **Clear duration:** exactly DEPTH cycles with busy=1. The first write occurs on the edge after clr_req is sampled. clr_done is asserted in the cycle after busy falls (busy=0, clr_done=1 for one cycle).
- **Counter:** ADDR_W bits; no wrap within a clear.
- **Reset mid-clear:** immediate abort. busy and clr_done go to 0; the contents already cleared stay zero, the rest are undefined.
- **Reset mid-read:** valids drop to 0 asynchronously.
- **Out-of-range address** (≥DEPTH, when DEPTH is not a power of two): the write is dropped; the read returns undefined data with valid=1.

## Structure
- Package seg_mem_pkg holds:
  - the clear FSM state enum (IDLE, CLEAR);
  - the storage-type enum (M20K, MLAB, REG);
  - function storage_sel(DEPTH, M20K_MIN, MLAB_MIN).
- Sub-module segment_memory_bank: one channel. It contains:
  - the storage selected by generate on storage_sel: bram_m20k, bram_mlab or reg_mem;
  - the collision compare and bypass register;
  - the early valid and output-stage registers.
- The top level contains the clear FSM and counter, and muxes the clear address/data onto every bank's write port.

## Test plan
1. NUM_CH=2, DEPTH=64: write ch0 addr5=0xA5, ch1 addr5=0x5A; read both at t+1 → rd_data_early = 0xA5/0x5A at t+2, rd_valid_early=2'b11.
2. Collision on ch0: wr addr9=0x1234 and rd addr9 in the same cycle → rd_data_early=0x1234 next cycle. Ch1 read of addr9 in the same cycle returns its old value.
3. Read with out_en[0] held low 3 cycles → rd_data[0] holds its prior value. Raising out_en loads the pending data on the next edge.
4. Fill all addresses with 0xFF, then pulse clr_req → busy=1 for 64 cycles, then one clr_done pulse; reads of all addresses return 0. rd_en asserted during busy gives rd_valid_early=0.
5. Assert rst_b low at clear cycle 20 → busy=0 and clr_done=0 at once; addresses 0..19 read 0.
6. Repeat scenarios 1 and 2 with DEPTH=16, 128 and 512 so that REG, MLAB and M20K storage are each exercised; results must be identical.

Source files
------------

// File: rtl/seg_mem_pkg.sv
// rtl/seg_mem_pkg.sv - shared types and storage selection for the segment memory
package seg_mem_pkg;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    typedef enum logic [1:0] {M20K, MLAB, REG} storage_t;

    function automatic storage_t storage_sel(int depth, int m20k_min, int mlab_min);
        if (depth >= m20k_min) return M20K;
        if (depth >= mlab_min) return MLAB;
        return REG;
    endfunction

endpackage

// File: rtl/segment_memory_bank.sv
// rtl/segment_memory_bank.sv - one channel: storage, write-first bypass, early and output stages
module segment_memory_bank
    import seg_mem_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int DATA_W   = 64,
    parameter int M20K_MIN = 256,
    parameter int MLAB_MIN = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              out_en,
    output logic [DATA_W-1:0] rd_data_early,
    output logic              rd_valid_early,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam storage_t STORE = storage_sel(DEPTH, M20K_MIN, MLAB_MIN);

    logic              hit;
    logic              wr_ok;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] byp;
    logic              byp_sel;

    assign hit   = rd_en & wr_en & (rd_addr == wr_addr);
    // Writes past the last word are dropped when DEPTH is not a power of two.
    assign wr_ok = wr_en & ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));

    if (STORE == M20K) begin : bram_m20k
        (* ramstyle = "M20K" *) logic [DATA_W-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_ok) mem[wr_addr] <= wr_data;
            if (rd_en && !hit) mem_q <= mem[rd_addr];
        end
    end else if (STORE == MLAB) begin : bram_mlab
        (* ramstyle = "MLAB" *) logic [DATA_W-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_ok) mem[wr_addr] <= wr_data;
            if (rd_en && !hit) mem_q <= mem[rd_addr];
        end
    end else begin : reg_mem
        (* ramstyle = "logic" *) logic [DATA_W-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_ok) mem[wr_addr] <= wr_data;
            if (rd_en && !hit) mem_q <= mem[rd_addr];
        end
    end

    // byp_sel comes out of reset set so the early port shows the zeroed bypass register.
    assign rd_data_early = byp_sel ? byp : mem_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            byp            <= '0;
            byp_sel        <= 1'b1;
            rd_valid_early <= 1'b0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
        end else begin
            rd_valid_early <= rd_en;
            if (rd_en) begin
                byp_sel <= hit;
                if (hit) byp <= wr_data;
            end
            if (out_en) begin
                rd_data  <= rd_data_early;
                rd_valid <= rd_valid_early;
            end
        end
    end

endmodule

// File: rtl/segment_memory_mc.sv
// rtl/segment_memory_mc.sv - multi-channel segment memory with hardware clear sequencer
module segment_memory_mc
    import seg_mem_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int DATA_W   = 64,
    parameter int M20K_MIN = 256,
    parameter int MLAB_MIN = 32
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done,
    input  logic [NUM_CH-1:0]        rd_en,
    input  logic [NUM_CH*ADDR_W-1:0] rd_addr,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic [NUM_CH-1:0]        out_en,
    output logic [NUM_CH*DATA_W-1:0] rd_data_early,
    output logic [NUM_CH-1:0]        rd_valid_early,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0]        rd_valid
);

    clr_state_t        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == ADDR_W'(DEPTH-1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    // While clearing, the sequencer owns every bank's write port and user reads are masked.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic              bank_re;
        logic              bank_we;
        logic [ADDR_W-1:0] bank_waddr;
        logic [DATA_W-1:0] bank_wdata;

        assign bank_re    = rd_en[c] & ~busy;
        assign bank_we    = busy | wr_en[c];
        assign bank_waddr = busy ? cnt : wr_addr[c*ADDR_W +: ADDR_W];
        assign bank_wdata = busy ? '0  : wr_data[c*DATA_W +: DATA_W];

        segment_memory_bank #(
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .M20K_MIN (M20K_MIN),
            .MLAB_MIN (MLAB_MIN)
        ) u_bank (
            .clk            (clk),
            .rst_b          (rst_b),
            .rd_en          (bank_re),
            .rd_addr        (rd_addr[c*ADDR_W +: ADDR_W]),
            .wr_en          (bank_we),
            .wr_addr        (bank_waddr),
            .wr_data        (bank_wdata),
            .out_en         (out_en[c]),
            .rd_data_early  (rd_data_early[c*DATA_W +: DATA_W]),
            .rd_valid_early (rd_valid_early[c]),
            .rd_data        (rd_data[c*DATA_W +: DATA_W]),
            .rd_valid       (rd_valid[c])
        );
    end

endmodule
